spi_master_burst: RTL and testbench

Parametrised SPI master with chip-select control and multi-word bursts. It generalises the byte-wide SPI master in three ways: a configurable word width, all four SPI modes, and a hardware-driven active-low chip select held across a burst of up to MAX_WORDS words. It sits between register/instruction sequencing logic (for example, an ADC command word followed by data words) and the external SPI pins.

---
 rtl/spi_master_burst_if.sv | 31 +++
 rtl/spi_master_burst.sv | 181 ++++++++++++++++++
 tb/tb_spi_master_burst.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_burst_if.sv
// Upstream word handshake plus SPI pins for spi_master_burst.
// The "master" modport is the SPI master block; "slave" is whatever drives it and the external pins.
interface spi_master_burst_if #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned MAX_WORDS  = 4
);
    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    logic [CNT_W-1:0]      tx_count;
    logic [WORD_WIDTH-1:0] tx_word;
    logic                  tx_dv;
    logic                  tx_ready;
    logic                  rx_dv;
    logic [WORD_WIDTH-1:0] rx_word;
    logic [IDX_W-1:0]      rx_count;
    logic                  spi_clk;
    logic                  spi_miso;
    logic                  spi_mosi;
    logic                  spi_cs_n;

    modport master (
        input  tx_count, tx_word, tx_dv, spi_miso,
        output tx_ready, rx_dv, rx_word, rx_count, spi_clk, spi_mosi, spi_cs_n
    );

    modport slave (
        output tx_count, tx_word, tx_dv, spi_miso,
        input  tx_ready, rx_dv, rx_word, rx_count, spi_clk, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_master_burst.sv
// SPI master with configurable word width and mode; holds chip select low across a burst of words.
module spi_master_burst #(
    parameter int unsigned SPI_MODE          = 0,
    parameter int unsigned CLKS_PER_HALF_BIT = 2,
    parameter int unsigned WORD_WIDTH        = 8,
    parameter int unsigned MAX_WORDS         = 4,
    parameter int unsigned CS_INACTIVE_CLKS  = 1
) (
    input  logic clk,
    input  logic rst_n,
    spi_master_burst_if.master bus
);
    localparam int unsigned W      = WORD_WIDTH;
    localparam int unsigned CHB    = CLKS_PER_HALF_BIT;
    localparam int unsigned CNT_W  = $clog2(MAX_WORDS + 1);
    localparam int unsigned IDX_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned EDGE_W = $clog2(2 * W + 1);
    localparam int unsigned TMAX   = (CHB > CS_INACTIVE_CLKS) ? CHB : CS_INACTIVE_CLKS;
    localparam int unsigned TW     = $clog2(TMAX + 1);
    localparam logic        CPOL   = 1'((SPI_MODE >> 1) & 1);
    localparam logic        CPHA   = 1'(SPI_MODE & 1);

    typedef enum logic [2:0] {IDLE, LEAD, XFER, WAIT_NEXT, CS_HOLD, CS_GAP} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d, last_idx_q, last_idx_d;
    logic [W-1:0]      tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic              ready_q, ready_d, rx_dv_q, rx_dv_d;
    logic [W-1:0]      rx_word_q, rx_word_d;
    logic [IDX_W-1:0]  rx_count_q, rx_count_d;

    logic              accept, half_done, sample, last_edge;
    logic [EDGE_W-1:0] edge_num;
    logic [CNT_W-1:0]  count_clamp;
    logic [W-1:0]      rx_next;

    // A word is taken only while ready; a zero count never starts a burst.
    assign accept      = bus.tx_dv && ready_q &&
                         ((state_q == IDLE && bus.tx_count != '0) || state_q == WAIT_NEXT);
    assign count_clamp = (bus.tx_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : bus.tx_count;
    assign half_done   = (tmr_q == TW'(CHB - 1));
    assign edge_num    = edge_q + EDGE_W'(1);
    // Odd edges are leading; CPHA=0 samples on leading, CPHA=1 on trailing.
    assign sample      = (edge_num[0] != CPHA);
    assign last_edge   = (edge_num == EDGE_W'(2 * W));
    assign rx_next     = {rx_sr_q[W-2:0], bus.spi_miso};

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        edge_d     = edge_q;
        word_idx_d = word_idx_q;
        last_idx_d = last_idx_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        ready_d    = ready_q;
        rx_dv_d    = 1'b0;
        rx_word_d  = rx_word_q;
        rx_count_d = rx_count_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                sclk_d  = CPOL;
            end
            LEAD, XFER: begin
                tmr_d = tmr_q + TW'(1);
                if (half_done) begin
                    tmr_d   = '0;
                    state_d = XFER;
                    edge_d  = edge_num;
                    sclk_d  = ~sclk_q;
                    if (sample) begin
                        rx_sr_d = rx_next;
                    end else if (!last_edge) begin
                        mosi_d  = tx_sr_q[W-1];
                        tx_sr_d = {tx_sr_q[W-2:0], 1'b0};
                    end
                    if (last_edge) begin
                        rx_dv_d    = 1'b1;
                        rx_word_d  = sample ? rx_next : rx_sr_q;
                        rx_count_d = word_idx_q;
                        if (word_idx_q == last_idx_q) begin
                            state_d = CS_HOLD;
                        end else begin
                            state_d = WAIT_NEXT;
                            ready_d = 1'b1;
                        end
                    end
                end
            end
            CS_HOLD: begin
                tmr_d = tmr_q + TW'(1);
                if (half_done) begin
                    tmr_d   = '0;
                    state_d = CS_GAP;
                    cs_n_d  = 1'b1;
                end
            end
            CS_GAP: begin
                tmr_d = tmr_q + TW'(1);
                if (tmr_q == TW'(CS_INACTIVE_CLKS - 1)) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Word load, shared by the first word of a burst and every follow-on word.
        if (accept) begin
            state_d = LEAD;
            tmr_d   = '0;
            edge_d  = '0;
            ready_d = 1'b0;
            cs_n_d  = 1'b0;
            if (CPHA == 1'b0) begin
                mosi_d  = bus.tx_word[W-1];
                tx_sr_d = {bus.tx_word[W-2:0], 1'b0};
            end else begin
                tx_sr_d = bus.tx_word;
            end
            if (state_q == IDLE) begin
                word_idx_d = '0;
                last_idx_d = IDX_W'(count_clamp - CNT_W'(1));
            end else begin
                word_idx_d = word_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            edge_q     <= '0;
            word_idx_q <= '0;
            last_idx_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            ready_q    <= 1'b0;
            rx_dv_q    <= 1'b0;
            rx_word_q  <= '0;
            rx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            edge_q     <= edge_d;
            word_idx_q <= word_idx_d;
            last_idx_q <= last_idx_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            ready_q    <= ready_d;
            rx_dv_q    <= rx_dv_d;
            rx_word_q  <= rx_word_d;
            rx_count_q <= rx_count_d;
        end
    end

    assign bus.tx_ready = ready_q;
    assign bus.rx_dv    = rx_dv_q;
    assign bus.rx_word  = rx_word_q;
    assign bus.rx_count = rx_count_q;
    assign bus.spi_clk  = sclk_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_cs_n = cs_n_q;
endmodule

// File: tb/tb_spi_master_burst.sv
// Directed bench: a loopback mode-3 byte master plus four 16-bit masters (modes 0..3) against slave models.
module tb_spi_master_burst;
    localparam int unsigned CHB   = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned MW    = 4;
    localparam int unsigned CHB16 = 2;
    localparam logic [15:0] SLV_WORD = 16'h3C5A;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_burst_if #(.WORD_WIDTH(W), .MAX_WORDS(MW)) mif ();
    assign mif.spi_miso = mif.spi_mosi;

    spi_master_burst #(
        .SPI_MODE(3), .CLKS_PER_HALF_BIT(CHB), .WORD_WIDTH(W),
        .MAX_WORDS(MW), .CS_INACTIVE_CLKS(1)
    ) u_dut (.clk(clk), .rst_n(rst_n), .bus(mif));

    // Monitor for the byte master, sampled just after each rising edge.
    int sclk_edges, cs_low, cs_rises, cs_rise_cyc, rdy_rise_cyc, rx_cyc, accept_next;
    logic prev_sclk = 1'b1, prev_cs = 1'b1, prev_rdy = 1'b0;
    logic [7:0] rxw_q[$];
    logic [1:0] rxc_q[$];

    always begin
        @(posedge clk);
        #1;
        if (mif.spi_clk != prev_sclk) sclk_edges++;
        if (!mif.spi_cs_n) cs_low++;
        if (mif.spi_cs_n && !prev_cs) begin
            cs_rises++;
            cs_rise_cyc = cyc;
        end
        if (mif.tx_ready && !prev_rdy) rdy_rise_cyc = cyc;
        if (mif.rx_dv) begin
            rxw_q.push_back(mif.rx_word);
            rxc_q.push_back(mif.rx_count);
            rx_cyc = cyc;
        end
        prev_sclk = mif.spi_clk;
        prev_cs   = mif.spi_cs_n;
        prev_rdy  = mif.tx_ready;
    end

    // Four 16-bit masters, one per SPI mode, sharing one stimulus.
    logic        t16_dv = 1'b0;
    logic [15:0] t16_word = '0;
    logic [2:0]  t16_count = '0;
    logic [63:0] res_srx, res_mrx;
    logic [31:0] res_fe;
    logic [3:0]  res_sclk, res_cs;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam logic CPOL = 1'(m / 2);
        localparam logic CPHA = 1'(m % 2);
        spi_master_burst_if #(.WORD_WIDTH(16), .MAX_WORDS(MW)) bus16 ();
        logic        miso = 1'b0;
        logic        s_prev_cs = 1'b1, s_prev_sclk = CPOL;
        logic [15:0] sh_in = '0, sh_out = '0, mrx = '0;
        int          cs_fall = 0, fe = 0;
        bit          got_first = 1'b0;

        assign bus16.tx_dv    = t16_dv;
        assign bus16.tx_word  = t16_word;
        assign bus16.tx_count = t16_count;
        assign bus16.spi_miso = miso;

        spi_master_burst #(
            .SPI_MODE(m), .CLKS_PER_HALF_BIT(CHB16), .WORD_WIDTH(16),
            .MAX_WORDS(MW), .CS_INACTIVE_CLKS(1)
        ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus16));

        // Behavioural slave: shifts in MOSI and returns SLV_WORD on MISO.
        always @(negedge clk) begin
            if (s_prev_cs && !bus16.spi_cs_n) begin
                sh_out    = SLV_WORD;
                cs_fall   = cyc;
                got_first = 1'b0;
                if (!CPHA) begin
                    miso   = sh_out[15];
                    sh_out = {sh_out[14:0], 1'b0};
                end
            end
            if (!bus16.spi_cs_n && bus16.spi_clk != s_prev_sclk) begin
                if (!got_first) begin
                    fe        = cyc - cs_fall;
                    got_first = 1'b1;
                end
                if ((bus16.spi_clk != CPOL) == !CPHA) begin
                    sh_in = {sh_in[14:0], bus16.spi_mosi};
                end else begin
                    miso   = sh_out[15];
                    sh_out = {sh_out[14:0], 1'b0};
                end
            end
            if (bus16.rx_dv) mrx = bus16.rx_word;
            s_prev_cs   = bus16.spi_cs_n;
            s_prev_sclk = bus16.spi_clk;
        end

        assign res_srx[m*16 +: 16] = sh_in;
        assign res_mrx[m*16 +: 16] = mrx;
        assign res_fe[m*8 +: 8]    = 8'(fe);
        assign res_sclk[m]         = bus16.spi_clk;
        assign res_cs[m]           = bus16.spi_cs_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        sclk_edges = 0; cs_low = 0; cs_rises = 0;
        cs_rise_cyc = 0; rdy_rise_cyc = 0; rx_cyc = 0;
        rxw_q.delete();
        rxc_q.delete();
    endtask

    task automatic send(input logic [7:0] w, input logic [2:0] n);
        int k = 0;
        @(negedge clk);
        while (!mif.tx_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("send_rdy", 32'(mif.tx_ready), 32'(1));
        mif.tx_dv    = 1'b1;
        mif.tx_word  = w;
        mif.tx_count = n;
        @(posedge clk);
        #1;
        accept_next = cyc;
        @(negedge clk);
        mif.tx_dv = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!(mif.spi_cs_n && mif.tx_ready) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("done", 32'(mif.spi_cs_n && mif.tx_ready), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int stall_bad;
        logic s_cs, s_sclk, s_mosi;
        mif.tx_dv = 1'b0; mif.tx_word = '0; mif.tx_count = '0;

        // Asynchronous reset, observed before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_cs", 32'(mif.spi_cs_n), 32'(1));
        check("rst_sclk", 32'(mif.spi_clk), 32'(1));
        check("rst_mosi", 32'(mif.spi_mosi), 32'(0));
        check("rst_rdy", 32'(mif.tx_ready), 32'(0));
        check("rst_rxdv", 32'(mif.rx_dv), 32'(0));
        check("rst_rxw", 32'(mif.rx_word), 32'(0));
        check("rst_rxc", 32'(mif.rx_count), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", 32'(mif.tx_ready), 32'(1));

        // Single word, mode 3 loopback
        clear_mon();
        send(8'hA5, 3'd1);
        wait_done();
        check("t1_edges", 32'(sclk_edges), 32'(16));
        check("t1_nrx", 32'(rxw_q.size()), 32'(1));
        check("t1_rxw", 32'(rxw_q[0]), 32'h A5);
        check("t1_rxc", 32'(rxc_q[0]), 32'(0));
        check("t1_cslow", 32'(cs_low), 32'(68));
        check("t1_rdy_gap", 32'(rdy_rise_cyc - cs_rise_cyc), 32'(1));
        check("t1_rx_lat", 32'(rx_cyc - accept_next), 32'(2 * W * CHB));
        check("t1_idle_sclk", 32'(mif.spi_clk), 32'(1));

        // Back-to-back burst of three
        clear_mon();
        send(8'hC1, 3'd3);
        send(8'hC3, 3'd0);
        send(8'hAA, 3'd0);
        wait_done();
        check("t2_nrx", 32'(rxw_q.size()), 32'(3));
        check("t2_w0", 32'(rxw_q[0]), 32'h C1);
        check("t2_w1", 32'(rxw_q[1]), 32'h C3);
        check("t2_w2", 32'(rxw_q[2]), 32'h AA);
        check("t2_c1", 32'(rxc_q[1]), 32'(1));
        check("t2_c2", 32'(rxc_q[2]), 32'(2));
        check("t2_cs_rises", 32'(cs_rises), 32'(1));
        check("t2_edges", 32'(sclk_edges), 32'(48));

        // Stall between words of a two-word burst
        clear_mon();
        send(8'h5A, 3'd2);
        k = 0;
        while (rxw_q.size() < 1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t3_first_rx", 32'(rxw_q.size()), 32'(1));
        s_cs = mif.spi_cs_n; s_sclk = mif.spi_clk; s_mosi = mif.spi_mosi;
        stall_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (mif.spi_cs_n != 1'b0 || mif.spi_clk != s_sclk || mif.spi_mosi != s_mosi)
                stall_bad++;
        end
        check("t3_stall_cs", 32'(s_cs), 32'(0));
        check("t3_stall_const", 32'(stall_bad), 32'(0));
        send(8'h96, 3'd0);
        wait_done();
        check("t3_w1", 32'(rxw_q[1]), 32'h 96);
        check("t3_c1", 32'(rxc_q[1]), 32'(1));
        check("t3_cs_rises", 32'(cs_rises), 32'(1));

        // Count above MAX_WORDS clamps to four words
        clear_mon();
        send(8'h11, 3'd7);
        send(8'h22, 3'd0);
        send(8'h33, 3'd0);
        send(8'h44, 3'd0);
        wait_done();
        check("t4_nrx", 32'(rxw_q.size()), 32'(4));
        check("t4_w3", 32'(rxw_q[3]), 32'h 44);
        check("t4_c3", 32'(rxc_q[3]), 32'(3));
        check("t4_cs_rises", 32'(cs_rises), 32'(1));

        // Zero count in IDLE is ignored
        clear_mon();
        @(negedge clk);
        mif.tx_dv = 1'b1; mif.tx_count = 3'd0; mif.tx_word = 8'hFF;
        @(negedge clk);
        mif.tx_dv = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_cslow", 32'(cs_low), 32'(0));
        check("t5_edges", 32'(sclk_edges), 32'(0));
        check("t5_rdy", 32'(mif.tx_ready), 32'(1));

        // Valid pulse during a transfer is ignored
        clear_mon();
        send(8'h69, 3'd1);
        repeat (20) @(negedge clk);
        mif.tx_dv = 1'b1; mif.tx_count = 3'd1; mif.tx_word = 8'hFF;
        @(negedge clk);
        mif.tx_dv = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        check("t6_nrx", 32'(rxw_q.size()), 32'(1));
        check("t6_rxw", 32'(rxw_q[0]), 32'h 69);
        check("t6_cslow", 32'(cs_low), 32'(68));
        check("t6_edges", 32'(sclk_edges), 32'(16));

        // All four modes, 16-bit words
        @(negedge clk);
        t16_dv = 1'b1; t16_word = 16'hC1C3; t16_count = 3'd1;
        @(negedge clk);
        t16_dv = 1'b0;
        repeat (100) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("m%0d_slave_rx", i), 32'(res_srx[i*16 +: 16]), 32'h C1C3);
            check($sformatf("m%0d_master_rx", i), 32'(res_mrx[i*16 +: 16]), 32'(SLV_WORD));
            check($sformatf("m%0d_first_edge", i), 32'(res_fe[i*8 +: 8]), 32'(CHB16));
            check($sformatf("m%0d_idle_sclk", i), 32'(res_sclk[i]), 32'(i / 2));
            check($sformatf("m%0d_cs", i), 32'(res_cs[i]), 32'(1));
        end

        // Reset at SPI edge 5 aborts the word
        clear_mon();
        send(8'hF0, 3'd1);
        k = 0;
        while (sclk_edges < 5 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t7_edge5", 32'(sclk_edges), 32'(5));
        rst_n = 1'b0;
        #1;
        check("t7_cs", 32'(mif.spi_cs_n), 32'(1));
        check("t7_sclk", 32'(mif.spi_clk), 32'(1));
        check("t7_rdy", 32'(mif.tx_ready), 32'(0));
        repeat (4) @(negedge clk);
        check("t7_no_rx", 32'(rxw_q.size()), 32'(0));
        rst_n = 1'b1;
        clear_mon();
        send(8'h3C, 3'd1);
        wait_done();
        check("t7_nrx", 32'(rxw_q.size()), 32'(1));
        check("t7_rxw", 32'(rxw_q[0]), 32'h 3C);
        check("t7_rxc", 32'(rxc_q[0]), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
